video_line_feeder: RTL and testbench

- Upstream neighbour of the video timing driver. A ping-pong line buffer in the pixel_clk domain.
- Accepts an RGB565 pixel stream with a valid/ready handshake and start-of-frame marking.
- Answers the driver's data_req/pixel_xpos/pixel_ypos requests with video_rgb_565 one cycle later.
- Inserts a fill colour on lines that are not ready (underrun).

---
 rtl/video_timing_pkg.sv | 29 ++
 rtl/line_ram_sdp.sv | 29 ++
 rtl/video_line_feeder.sv | 164 ++++++++++++++++
 tb/tb_video_line_feeder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared video timing constants (1024x768 @ 60 Hz) and RGB565 field widths,
// common to the line feeder and the video timing driver.
package video_timing_pkg;

   localparam int H_DISP  = 1024;
   localparam int H_FRONT = 24;
   localparam int H_SYNC  = 136;
   localparam int H_BACK  = 160;
   localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;

   localparam int V_DISP  = 768;
   localparam int V_FRONT = 3;
   localparam int V_SYNC  = 6;
   localparam int V_BACK  = 29;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

   localparam int RGB_R_W = 5;
   localparam int RGB_G_W = 6;
   localparam int RGB_B_W = 5;
   localparam int RGB_W   = RGB_R_W + RGB_G_W + RGB_B_W;

   // What the pixel output shows in the cycle after a request.
   typedef enum logic [1:0] {
      OUT_ZERO,
      OUT_FILL,
      OUT_RAM
   } out_sel_e;

endpackage

// File: rtl/line_ram_sdp.sv
// Simple-dual-port RAM: synchronous write, registered read with one cycle
// of latency.
module line_ram_sdp #(
   parameter int DEPTH = 2048,
   parameter int WIDTH = 16
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // NOTE: the array has no reset so it maps onto block RAM; contents are
   // only ever read after the write side has marked a bank full.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/video_line_feeder.sv
// Ping-pong line buffer between an RGB565 valid/ready stream and the video
// timing driver's data_req/xpos/ypos pixel requests.
module video_line_feeder #(
   parameter int          H_DISP     = 1024,
   parameter int          V_DISP     = 768,
   parameter int          IDX_W      = 10,
   parameter logic [15:0] FILL_COLOR = 16'h0000
) (
   input  logic        pixel_clk,
   input  logic        sys_rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   input  logic        in_sof,
   input  logic        data_req,
   input  logic [10:0] pixel_xpos,
   input  logic [10:0] pixel_ypos,
   output logic [15:0] video_rgb_565,
   output logic        underrun,
   output logic [15:0] underrun_cnt
);

   import video_timing_pkg::*;

   localparam int          AW    = IDX_W + 1;
   // Bank-major {bank, idx} packing spans a full power-of-two per bank.
   localparam int          DEPTH = 2 ** AW;
   localparam logic [10:0] XLAST = 11'(H_DISP);

   if (H_DISP > (2 ** IDX_W) || H_DISP < 2 || V_DISP < 1) begin : g_bad_params
      $error("video_line_feeder: H_DISP must be in 2..2**IDX_W and V_DISP >= 1");
   end

   logic [1:0]       full_q, full_d;
   logic [1:0]       sof_tag_q, sof_tag_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [IDX_W-1:0] wr_cnt_q, wr_cnt_d;
   logic             line_ok_q, line_ok_d;
   logic             underrun_q, underrun_d;
   logic [15:0]      underrun_cnt_q, underrun_cnt_d;
   out_sel_e         sel_q, sel_d;

   logic             wr_fire, wr_last;
   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic             x_in_range, line_start, line_ok_now, line_ok_eff;
   logic [15:0]      ram_rdata;

   assign in_ready = !full_q[wr_bank_q];
   assign wr_fire  = in_valid && in_ready;
   assign wr_idx   = in_sof ? '0 : wr_cnt_q;
   assign wr_last  = (wr_idx == IDX_W'(H_DISP - 1));

   assign x_in_range  = (pixel_xpos != 11'd0) && (pixel_xpos <= XLAST);
   assign line_start  = data_req && (pixel_xpos == 11'd1);
   assign line_ok_now = full_q[rd_bank_q] && ((pixel_ypos != 11'd1) || sof_tag_q[rd_bank_q]);
   // The first request of a line is served with the decision being latched.
   assign line_ok_eff = line_start ? line_ok_now : line_ok_q;
   assign rd_idx      = IDX_W'(pixel_xpos - 11'd1);

   // NOTE: every variable gets its default before any branch so no path
   // leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      full_d         = full_q;
      sof_tag_d      = sof_tag_q;
      wr_bank_d      = wr_bank_q;
      rd_bank_d      = rd_bank_q;
      wr_cnt_d       = wr_cnt_q;
      line_ok_d      = line_ok_q;
      underrun_d     = 1'b0;
      underrun_cnt_d = underrun_cnt_q;
      sel_d          = OUT_ZERO;

      if (wr_fire) begin
         if (in_sof) begin
            sof_tag_d[wr_bank_q] = 1'b1;
         end else if (wr_cnt_q == '0) begin
            sof_tag_d[wr_bank_q] = 1'b0;
         end
         if (wr_last) begin
            full_d[wr_bank_q] = 1'b1;
            wr_cnt_d          = '0;
            wr_bank_d         = !wr_bank_q;
         end else begin
            wr_cnt_d = wr_idx + IDX_W'(1);
         end
      end

      // Reader only clears rd_bank_q; a write can only set the other bank.
      if (line_start) begin
         line_ok_d = line_ok_now;
         if (!line_ok_now) begin
            underrun_d = 1'b1;
            if (underrun_cnt_q != 16'hFFFF) begin
               underrun_cnt_d = underrun_cnt_q + 16'd1;
            end
            // A full bank without its frame tag at ypos 1 is dropped to resync.
            if (full_q[rd_bank_q]) begin
               full_d[rd_bank_q] = 1'b0;
               rd_bank_d         = !rd_bank_q;
            end
         end
      end

      if (data_req && (pixel_xpos == XLAST) && line_ok_eff) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = !rd_bank_q;
      end

      if (data_req) begin
         sel_d = (x_in_range && line_ok_eff) ? OUT_RAM : OUT_FILL;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples its _d value from the same clock edge.
   always_ff @(posedge pixel_clk) begin
      if (sys_rst) begin
         full_q         <= '0;
         sof_tag_q      <= '0;
         wr_bank_q      <= 1'b0;
         rd_bank_q      <= 1'b0;
         wr_cnt_q       <= '0;
         line_ok_q      <= 1'b0;
         underrun_q     <= 1'b0;
         underrun_cnt_q <= '0;
         sel_q          <= OUT_ZERO;
      end else begin
         full_q         <= full_d;
         sof_tag_q      <= sof_tag_d;
         wr_bank_q      <= wr_bank_d;
         rd_bank_q      <= rd_bank_d;
         wr_cnt_q       <= wr_cnt_d;
         line_ok_q      <= line_ok_d;
         underrun_q     <= underrun_d;
         underrun_cnt_q <= underrun_cnt_d;
         sel_q          <= sel_d;
      end
   end

   line_ram_sdp #(
      .DEPTH (DEPTH),
      .WIDTH (16)
   ) u_line_ram (
      .clk_i   (pixel_clk),
      .we_i    (wr_fire),
      .waddr_i ({wr_bank_q, wr_idx}),
      .wdata_i (in_data),
      .raddr_i ({rd_bank_q, rd_idx}),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      unique case (sel_q)
         OUT_RAM:  video_rgb_565 = ram_rdata;
         OUT_FILL: video_rgb_565 = FILL_COLOR;
         default:  video_rgb_565 = 16'h0000;
      endcase
   end

   assign underrun     = underrun_q;
   assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_video_line_feeder.sv
// Bench for video_line_feeder: directed scenarios plus random traffic, checked
// against a line-FIFO reference model (completed lines queue, max two).
module tb_video_line_feeder;

   localparam int          H    = 1024;
   localparam logic [15:0] FILL = 16'h0000;

   logic        pixel_clk = 1'b0;
   logic        sys_rst   = 1'b1;
   logic        in_valid  = 1'b0;
   logic        in_ready;
   logic [15:0] in_data   = '0;
   logic        in_sof    = 1'b0;
   logic        data_req  = 1'b0;
   logic [10:0] pixel_xpos = '0;
   logic [10:0] pixel_ypos = '0;
   logic [15:0] video_rgb_565;
   logic        underrun;
   logic [15:0] underrun_cnt;

   int total = 0;
   int bad   = 0;

   // Reference model: completed lines in arrival order, plus the line being assembled.
   logic [15:0] m_pix[$];
   bit          m_sof[$];
   logic [15:0] m_part[$];
   bit          m_part_sof;
   bit          m_cur_ok;
   int          m_cnt;

   video_line_feeder #(
      .H_DISP     (H),
      .V_DISP     (768),
      .IDX_W      (10),
      .FILL_COLOR (FILL)
   ) dut (
      .pixel_clk     (pixel_clk),
      .sys_rst       (sys_rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_sof        (in_sof),
      .data_req      (data_req),
      .pixel_xpos    (pixel_xpos),
      .pixel_ypos    (pixel_ypos),
      .video_rgb_565 (video_rgb_565),
      .underrun      (underrun),
      .underrun_cnt  (underrun_cnt)
   );

   always #5 pixel_clk = ~pixel_clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "bench timed out");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s @%0t: observed=%0h expected=%0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pix.delete();
      m_sof.delete();
      m_part.delete();
      m_part_sof = 1'b0;
      m_cur_ok   = 1'b0;
      m_cnt      = 0;
   endtask

   task automatic pop_line();
      for (int i = 0; i < H; i++) void'(m_pix.pop_front());
      void'(m_sof.pop_front());
   endtask

   // One clock: drive inputs, check in_ready, advance the model, check outputs.
   task automatic step(input logic v, input logic [15:0] d, input logic s,
                       input logic r, input logic [10:0] x, input logic [10:0] y);
      bit          exp_ready, exp_ur, ok;
      logic [15:0] exp_v;
      int          xi;
      in_valid = v; in_data = d; in_sof = s;
      data_req = r; pixel_xpos = x; pixel_ypos = y;
      xi = int'(x);
      exp_ready = (m_sof.size() < 2);
      check("in_ready", in_ready, exp_ready);
      exp_ur = 1'b0;
      if (!r) begin
         exp_v = 16'h0000;
      end else if (xi >= 1 && xi <= H) begin
         if (xi == 1) begin
            ok = (m_sof.size() > 0) && (y != 11'd1 || m_sof[0]);
            if (!ok) begin
               exp_ur = 1'b1;
               if (m_cnt < 65535) m_cnt++;
               if (m_sof.size() > 0 && y == 11'd1) pop_line();
            end
            m_cur_ok = ok;
         end
         exp_v = m_cur_ok ? m_pix[xi-1] : FILL;
         if (xi == H && m_cur_ok) pop_line();
      end else begin
         exp_v = FILL;
      end
      if (v && exp_ready) begin
         if (s) begin
            m_part.delete();
            m_part_sof = 1'b1;
         end else if (m_part.size() == 0) begin
            m_part_sof = 1'b0;
         end
         m_part.push_back(d);
         if (m_part.size() == H) begin
            foreach (m_part[i]) m_pix.push_back(m_part[i]);
            m_sof.push_back(m_part_sof);
            m_part.delete();
         end
      end
      @(posedge pixel_clk);
      #1;
      check("video_rgb_565", video_rgb_565, exp_v);
      check("underrun", underrun, exp_ur);
      check("underrun_cnt", underrun_cnt, m_cnt);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      in_valid = 1'b0; in_sof = 1'b0; data_req = 1'b0;
      pixel_xpos = '0; pixel_ypos = '0;
      @(posedge pixel_clk);
      #1;
      sys_rst = 1'b0;
      model_reset();
      check("rst_video", video_rgb_565, 16'h0000);
      check("rst_underrun", underrun, 1'b0);
      check("rst_cnt", underrun_cnt, 16'h0000);
      check("rst_in_ready", in_ready, 1'b1);
   endtask

   // Push n pixels, one per cycle; optional in_sof on the first, data = base+idx or random.
   task automatic push_px(input int n, input bit sof_first, input bit use_idx);
      for (int i = 0; i < n; i++)
         step(1'b1, use_idx ? 16'(i) : 16'($urandom), sof_first && i == 0,
              1'b0, '0, '0);
   endtask

   // Request one full line; wmode 0 = no writes, 1 = valid held, 2 = random traffic.
   task automatic req_line(input int y, input int wmode);
      logic v, s;
      for (int x = 1; x <= H; x++) begin
         v = (wmode == 1) || (wmode == 2 && $urandom_range(0, 3) != 0);
         s = (wmode == 2) && ($urandom_range(0, 511) == 0);
         step(v, 16'($urandom), s, 1'b1, 11'(x), 11'(y));
      end
      step(1'b0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge pixel_clk);
      #1;
      do_reset();

      // Empty buffer: whole line of fill, single underrun pulse.
      req_line(1, 0);
      check("t2_cnt_one", underrun_cnt, 16'd1);

      // Two lines with pixel value = idx, then display them.
      do_reset();
      push_px(H, 1'b1, 1'b1);
      push_px(H, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 16'hBEEF, 1'b0, 1'b0, '0, '0);
      check("t1_full_ready", in_ready, 1'b0);
      req_line(1, 0);
      req_line(2, 0);
      check("t1_no_underrun", underrun_cnt, 16'd0);

      // Backpressure while both banks full, release while valid held.
      push_px(H, 1'b1, 1'b0);
      push_px(H, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, '0, '0);
      req_line(1, 1);

      // Refill to full, then reset drops everything.
      for (int i = 0; i < 3000 && m_sof.size() < 2; i++)
         step(1'b1, 16'($urandom), 1'b0, 1'b0, '0, '0);
      check("t6_full_before_rst", in_ready, 1'b0);
      do_reset();
      req_line(5, 0);
      check("t6_cnt_after", underrun_cnt, 16'd1);

      // Untagged bank at frame start is dropped; next tagged line shows.
      do_reset();
      push_px(H, 1'b0, 1'b0);
      req_line(1, 0);
      push_px(H, 1'b1, 1'b0);
      req_line(1, 0);
      check("t4_cnt", underrun_cnt, 16'd1);

      // Mid-line in_sof discards the partial line.
      do_reset();
      push_px(300, 1'b0, 1'b0);
      push_px(H, 1'b1, 1'b0);
      req_line(1, 0);
      check("t5_cnt", underrun_cnt, 16'd0);

      // Random traffic with out-of-range requests between lines.
      do_reset();
      for (int ln = 0; ln < 8; ln++) begin
         req_line((ln % 3) + 1, 2);
         step(1'b1, 16'($urandom), 1'b0, 1'b1, 11'd0, 11'd2);
         step(1'b1, 16'($urandom), 1'b0, 1'b1, 11'(H + 1), 11'd2);
         for (int i = 0; i < int'($urandom_range(1, 40)); i++)
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 1'b0, '0, '0);
      end
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
